vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive side of the team's VGA timing interface: consumes the window-style sync pair (Hsync high = active pixel, Vsync high = active line) and 3-bit RGB produced by the VGA controller.
- Reconstructs pixel X/Y coordinates, measures line width and frame height, and checks them against expected geometry.
- Declares lock after consecutive good frames; feeds frame-capture and self-test logic on the display path.

Parameters:
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- LOCK_FRAMES, 3, consecutive good frames required to lock (1..15)
- TIMEOUT, 1000000, clocks without a Vsync edge before lock is abandoned

Ports:
- Clock  in  1  pixel clock; all inputs synchronous to it
- Reset  in  1  asynchronous, active-low reset
- iHsync  in  1  high during active pixels of a line
- iVsync  in  1  high during active lines of a frame
- iVGA_RGB  in  3  pixel colour
- oRGB  out  3  registered pixel colour
- oX  out  10  column of oRGB
- oY  out  10  row of oRGB
- oPixelValid  out  1  oRGB/oX/oY valid
- oFrameStart  out  1  one-cycle pulse, first pixel of a frame
- oLineWidth  out  10  last measured active pixels per line
- oFrameHeight  out  10  last measured active lines per frame
- oLocked  out  1  geometry locked
- oError  out  1  one-cycle pulse on loss of lock

Behaviour:
- Reset (Reset=0, asynchronous): all outputs 0, state SEARCH, all counters and flags 0. Reset mid-frame discards the partial frame.
- Input pipeline: iHsync/iVsync/iVGA_RGB registered twice (s1, s2).
  - H rise = s1&~s2; H fall = ~s1&s2; same for V.
- X counter:
  - Increments each cycle with s1 Hsync and s1 Vsync high; cleared on H fall.
  - Saturates at 1023.
- Y counter:
  - Increments on H fall while s1 Vsync high; cleared on V rise.
  - Saturates at 1023.
- Pixel outputs:
  - oPixelValid=1 only in TRACK or LOCKED, with s1 Hsync and s1 Vsync both high.
  - oRGB, oX, oY show that pixel's value and coordinates (pre-increment); latency = 2 clocks from input to output.
  - When oPixelValid=0: oRGB=0; oX/oY hold their last values.
- oFrameStart: high with the valid pixel where oX=0 and oY=0.
- Line check: on H fall with Vsync active:
  - oLineWidth <= X count.
  - If X count != H_ACTIVE, set sticky flag lineBad.
- Frame end: on V fall:
  - oFrameHeight <= Y count.
  - Frame is good iff lineBad=0 and Y count == V_ACTIVE.
  - lineBad cleared afterwards.
- H fall and V fall in the same cycle: line check is applied first, then frame end, and the last line counts toward Y.
- States:
  - SEARCH: outputs invalid; on V fall -> TRACK, goodCnt=0 (partial frame ignored).
  - TRACK: on frame end, good -> goodCnt+1; bad -> goodCnt=0, stay. When goodCnt reaches LOCK_FRAMES -> LOCKED; oLocked=1 from the next cycle.
  - LOCKED: on bad frame -> SEARCH, oLocked=0, oError pulse 1 cycle.
- Timeout:
  - Counter clears on any V edge and saturates.
  - Reaching TIMEOUT in TRACK or LOCKED -> SEARCH; oError pulses only if leaving LOCKED.
- In SEARCH, the measurement registers still update on edges.

Test Plan:
- Reset=0 while inputs toggle -> every output 0 and state SEARCH; release Reset -> stays SEARCH until the first Vsync fall.
- H_ACTIVE=8, V_ACTIVE=4, LOCK_FRAMES=3; drive 1 partial + 3 exact frames (8 px high, 4 px gap) -> oLocked=1 one cycle after the 3rd frame's V fall; oFrameHeight=4, oLineWidth=8.
- Locked, feed RGB=pixel index mod 8 -> oRGB matches 2 clocks later; oX sweeps 0..7, oY 0..3; oFrameStart once per frame at (0,0).
- Locked, one line of 9 px in a frame -> at that V fall oLocked=0, oError pulses once, state SEARCH; 1 partial + 3 good frames relock.
- TRACK with goodCnt=2, frame of 5 lines -> goodCnt=0, no lock, no oError.
- Locked, TIMEOUT=100, inputs held low 100 clocks -> oLocked=0, single oError pulse.
- Reset asserted mid-line while locked -> immediate all-zero outputs; no oError pulse.

Source files
------------

// File: rtl/vga_sync_decoder_if.sv
// VGA receive-side bundle: window-style sync pair plus 3-bit colour into the
// decoder, and reconstructed pixel stream, geometry and lock status out.
//   master : the video source / consumer side (drives iHsync, iVsync, iVGA_RGB)
//   slave  : the decoder (drives every o* signal)
interface vga_sync_decoder_if;
  logic       iHsync;
  logic       iVsync;
  logic [2:0] iVGA_RGB;
  logic [2:0] oRGB;
  logic [9:0] oX;
  logic [9:0] oY;
  logic       oPixelValid;
  logic       oFrameStart;
  logic [9:0] oLineWidth;
  logic [9:0] oFrameHeight;
  logic       oLocked;
  logic       oError;

  modport master (
    output iHsync, iVsync, iVGA_RGB,
    input  oRGB, oX, oY, oPixelValid, oFrameStart,
    input  oLineWidth, oFrameHeight, oLocked, oError
  );

  modport slave (
    input  iHsync, iVsync, iVGA_RGB,
    output oRGB, oX, oY, oPixelValid, oFrameStart,
    output oLineWidth, oFrameHeight, oLocked, oError
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: rebuilds pixel X/Y from the window-style Hsync/Vsync pair,
// measures line width and frame height, and locks once LOCK_FRAMES consecutive
// frames match the expected geometry.
//   Clock : pixel clock, every input is synchronous to it
//   Reset : asynchronous, active-low
//   vif   : slave side of vga_sync_decoder_if (sync/colour in, pixel stream,
//           measurements, oLocked and the one-cycle oError loss-of-lock pulse out)
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 3,
  parameter int TIMEOUT     = 1000000
) (
  input logic               Clock,
  input logic               Reset,
  vga_sync_decoder_if.slave vif
);

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [9:0]      H_EXP   = 10'(H_ACTIVE);
  localparam logic [9:0]      V_EXP   = 10'(V_ACTIVE);
  localparam logic [3:0]      LOCK_N  = 4'(LOCK_FRAMES);
  localparam logic [9:0]      CNT_MAX = 10'h3FF;

  state_t          state_q, state_d;
  logic            hs1_q, hs1_d, hs2_q, hs2_d;
  logic            vs1_q, vs1_d, vs2_q, vs2_d;
  logic [2:0]      rgb1_q, rgb1_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic            line_bad_q, line_bad_d;
  logic [3:0]      good_cnt_q, good_cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [2:0]      rgb_out_q, rgb_out_d;
  logic [9:0]      x_out_q, x_out_d, y_out_q, y_out_d;
  logic            valid_q, valid_d, fs_q, fs_d;
  logic [9:0]      lw_q, lw_d, fh_q, fh_d;
  logic            locked_q, locked_d, err_q, err_d;

  logic            h_fall, v_rise, v_fall, v_edge;
  logic            line_end, line_bad_now, frame_good, timeout_hit;
  logic [9:0]      y_eff, y_cur;

  always_comb begin
    hs1_d  = vif.iHsync;
    vs1_d  = vif.iVsync;
    rgb1_d = vif.iVGA_RGB;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;

    h_fall = ~hs1_q & hs2_q;
    v_rise = vs1_q & ~vs2_q;
    v_fall = ~vs1_q & vs2_q;
    v_edge = v_rise | v_fall;

    // A line ending in the same cycle Vsync drops still belongs to the frame,
    // so "Vsync active" for the line check includes the falling cycle.
    line_end     = h_fall & (vs1_q | vs2_q);
    line_bad_now = line_end & (x_q != H_EXP);
    // Y as seen by frame end: the coincident last line is counted here.
    y_eff        = (line_end && (y_q != CNT_MAX)) ? y_q + 10'd1 : y_q;
    frame_good   = ~(line_bad_q | line_bad_now) & (y_eff == V_EXP);
    // First line of a frame may start on the very cycle Vsync rises.
    y_cur        = v_rise ? 10'd0 : y_q;
    timeout_hit  = (to_q == TO_MAX) & ~v_edge;

    x_d = x_q;
    if (h_fall)
      x_d = 10'd0;
    else if (hs1_q && vs1_q && (x_q != CNT_MAX))
      x_d = x_q + 10'd1;

    y_d = y_q;
    if (v_rise)
      y_d = 10'd0;
    else if (h_fall && vs1_q && (y_q != CNT_MAX))
      y_d = y_q + 10'd1;

    lw_d       = line_end ? x_q : lw_q;
    line_bad_d = line_bad_q | line_bad_now;
    fh_d       = fh_q;
    if (v_fall) begin
      fh_d       = y_eff;
      line_bad_d = 1'b0;
    end

    to_d = to_q;
    if (v_edge)
      to_d = '0;
    else if (to_q != TO_MAX)
      to_d = to_q + TO_W'(1);

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      SEARCH: begin
        // The frame in progress when we start listening is never judged.
        if (v_fall) begin
          state_d    = TRACK;
          good_cnt_d = 4'd0;
        end
      end
      TRACK: begin
        if (timeout_hit) begin
          state_d    = SEARCH;
          good_cnt_d = 4'd0;
        end else if (v_fall) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if ((good_cnt_q + 4'd1) == LOCK_N)
              state_d = LOCKED;
          end else begin
            good_cnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (timeout_hit || (v_fall && !frame_good)) begin
          state_d    = SEARCH;
          good_cnt_d = 4'd0;
          err_d      = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCKED);

    valid_d   = ((state_q == TRACK) || (state_q == LOCKED)) && hs1_q && vs1_q;
    rgb_out_d = valid_d ? rgb1_q : 3'd0;
    x_out_d   = valid_d ? x_q    : x_out_q;
    y_out_d   = valid_d ? y_cur  : y_out_q;
    fs_d      = valid_d && (x_q == 10'd0) && (y_cur == 10'd0);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= SEARCH;
      hs1_q      <= 1'b0;
      hs2_q      <= 1'b0;
      vs1_q      <= 1'b0;
      vs2_q      <= 1'b0;
      rgb1_q     <= 3'd0;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      line_bad_q <= 1'b0;
      good_cnt_q <= 4'd0;
      to_q       <= '0;
      rgb_out_q  <= 3'd0;
      x_out_q    <= 10'd0;
      y_out_q    <= 10'd0;
      valid_q    <= 1'b0;
      fs_q       <= 1'b0;
      lw_q       <= 10'd0;
      fh_q       <= 10'd0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hs1_q      <= hs1_d;
      hs2_q      <= hs2_d;
      vs1_q      <= vs1_d;
      vs2_q      <= vs2_d;
      rgb1_q     <= rgb1_d;
      x_q        <= x_d;
      y_q        <= y_d;
      line_bad_q <= line_bad_d;
      good_cnt_q <= good_cnt_d;
      to_q       <= to_d;
      rgb_out_q  <= rgb_out_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      valid_q    <= valid_d;
      fs_q       <= fs_d;
      lw_q       <= lw_d;
      fh_q       <= fh_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign vif.oRGB         = rgb_out_q;
  assign vif.oX           = x_out_q;
  assign vif.oY           = y_out_q;
  assign vif.oPixelValid  = valid_q;
  assign vif.oFrameStart  = fs_q;
  assign vif.oLineWidth   = lw_q;
  assign vif.oFrameHeight = fh_q;
  assign vif.oLocked      = locked_q;
  assign vif.oError       = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder with small geometry (8x4, lock after 3 frames,
// timeout 100). Random frames are driven; expected pixels go into a queue that
// an independent monitor drains, and the lock/error behaviour is predicted by a
// frame-level model of the search/track/locked rules.
module tb_vga_sync_decoder;
  localparam int H_ACT  = 8;
  localparam int V_ACT  = 4;
  localparam int LOCK_N = 3;
  localparam int TMO    = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_sync_decoder_if vif ();

  vga_sync_decoder #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .LOCK_FRAMES(LOCK_N), .TIMEOUT(TMO)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .vif  (vif)
  );

  typedef struct {
    logic [2:0] rgb;
    int         x;
    int         y;
  } pix_t;

  pix_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   err_seen    = 0;
  int   frame_no    = 0;
  // frame-level model: 0 = searching, 1 = tracking, 2 = locked
  int   m_state     = 0;
  int   m_gc        = 0;
  int   m_err       = 0;
  int   fw[16];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic any_out();
    return |{vif.oRGB, vif.oX, vif.oY, vif.oPixelValid, vif.oFrameStart,
             vif.oLineWidth, vif.oFrameHeight, vif.oLocked, vif.oError};
  endfunction

  // Monitor: pops one expected pixel per valid output beat.
  always @(negedge clk) begin
    pix_t p;
    if (vif.oError) err_seen++;
    if (vif.oPixelValid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 1, 0);
      end else begin
        p = exp_q.pop_front();
        check("pix_rgb", int'(vif.oRGB), int'(p.rgb));
        check("pix_x", int'(vif.oX), p.x);
        check("pix_y", int'(vif.oY), p.y);
        check("frame_start", int'(vif.oFrameStart), int'(p.x == 0 && p.y == 0));
      end
    end else if (rst_n) begin
      check("rgb_idle_zero", int'(vif.oRGB), 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_widths(input int n, input int bad_line, input int bad_w);
    for (int i = 0; i < 16; i++) fw[i] = H_ACT;
    if (bad_line >= 0 && bad_line < n) fw[bad_line] = bad_w;
  endtask

  // Drives one whole frame: Vsync window with nlines lines of fw[l] pixels.
  // simul=1 drops Vsync together with the last Hsync fall.
  task automatic drive_frame(input int nlines, input bit simul);
    bit         active, pre_locked, good, exp_err;
    logic [2:0] c;
    active     = (m_state != 0);
    pre_locked = (m_state == 2);
    vif.iVsync = 1'b1;
    vif.iHsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < nlines; l++) begin
      for (int x = 0; x < fw[l]; x++) begin
        c            = 3'($urandom);
        vif.iHsync   = 1'b1;
        vif.iVGA_RGB = c;
        if (active) exp_q.push_back('{c, x, l});
        @(negedge clk);
      end
      vif.iHsync   = 1'b0;
      vif.iVGA_RGB = 3'($urandom);
      if (simul && l == nlines - 1) vif.iVsync = 1'b0;
      else repeat (4) @(negedge clk);
    end
    vif.iVsync = 1'b0;

    good = (nlines == V_ACT);
    for (int l = 0; l < nlines; l++) if (fw[l] != H_ACT) good = 1'b0;
    exp_err = 1'b0;
    case (m_state)
      0: begin m_state = 1; m_gc = 0; end
      1: begin
        if (good) begin
          m_gc++;
          if (m_gc == LOCK_N) m_state = 2;
        end else m_gc = 0;
      end
      default: begin
        if (!good) begin m_state = 0; m_gc = 0; m_err++; exp_err = 1'b1; end
      end
    endcase

    @(negedge clk);
    check("lock_hold", int'(vif.oLocked), int'(pre_locked));
    @(negedge clk);
    check("lock_after", int'(vif.oLocked), int'(m_state == 2));
    check("err_pulse", int'(vif.oError), int'(exp_err));
    repeat (4) @(negedge clk);
    check("frame_height", int'(vif.oFrameHeight), nlines);
    check("line_width", int'(vif.oLineWidth), fw[nlines-1]);
    check("err_count", err_seen, m_err);
    check("pixels_drained", exp_q.size(), 0);
    $display("frame %0d: lines=%0d last_w=%0d simul=%0b good=%0b state=%0d locked=%0b",
             frame_no, nlines, fw[nlines-1], simul, good, m_state, vif.oLocked);
    frame_no++;
  endtask

  task automatic partial_frame();
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < 16; i++) fw[i] = $urandom_range(2, 10);
    drive_frame(n, 1'($urandom));
  endtask

  task automatic good_frames(input int k);
    for (int i = 0; i < k; i++) begin
      set_widths(V_ACT, -1, 0);
      drive_frame(V_ACT, 1'($urandom));
    end
  endtask

  initial begin
    vif.iHsync   = 1'b0;
    vif.iVsync   = 1'b0;
    vif.iVGA_RGB = 3'd0;
    #2 rst_n = 1'b0;

    // Reset held while inputs toggle: every output stays zero.
    repeat (16) begin
      @(negedge clk);
      check("reset_zero", int'(any_out()), 0);
      vif.iHsync   = 1'($urandom);
      vif.iVsync   = 1'($urandom);
      vif.iVGA_RGB = 3'($urandom);
    end
    vif.iHsync = 1'b0; vif.iVsync = 1'b0; vif.iVGA_RGB = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    // Hsync activity without a Vsync fall keeps the decoder searching.
    repeat (20) begin
      vif.iHsync = 1'($urandom);
      @(negedge clk);
    end
    vif.iHsync = 1'b0;
    @(negedge clk);
    check("search_after_reset", int'(vif.oLocked), 0);

    // Partial + 3 exact frames lock; then a few locked frames.
    partial_frame();
    good_frames(3 + 4);

    // One 9-pixel line breaks lock; relock afterwards.
    set_widths(V_ACT, 1, H_ACT + 1);
    drive_frame(V_ACT, 1'b0);
    partial_frame();
    good_frames(3);

    // Timeout while locked.
    vif.iHsync = 1'b0; vif.iVsync = 1'b0;
    repeat (TMO + 20) @(negedge clk);
    if (m_state == 2) m_err++;
    m_state = 0; m_gc = 0;
    check("timeout_unlock", int'(vif.oLocked), 0);
    check("timeout_err_count", err_seen, m_err);

    // Tracking with two good frames, then a 5-line frame: no lock, no error.
    partial_frame();
    good_frames(2);
    set_widths(V_ACT + 1, -1, 0);
    drive_frame(V_ACT + 1, 1'b1);
    good_frames(3);

    // Reset in the middle of a line while locked.
    vif.iVsync = 1'b1; vif.iHsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int x = 0; x < 5; x++) begin
      logic [2:0] c;
      c = 3'($urandom);
      vif.iHsync = 1'b1; vif.iVGA_RGB = c;
      if (m_state != 0) exp_q.push_back('{c, x, 0});
      @(negedge clk);
    end
    #1 rst_n = 1'b0;
    exp_q.delete();
    m_state = 0; m_gc = 0;
    #1 check("midline_reset_zero", int'(any_out()), 0);
    vif.iHsync = 1'b0; vif.iVsync = 1'b0; vif.iVGA_RGB = 3'd0;
    repeat (4) @(negedge clk);
    check("midline_reset_no_err", err_seen, m_err);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Random geometry frames.
    partial_frame();
    for (int f = 0; f < 24; f++) begin
      int n;
      n = V_ACT;
      if ($urandom_range(0, 4) == 0) n = $urandom_range(0, 1) ? V_ACT + 1 : V_ACT - 1;
      for (int i = 0; i < 16; i++) begin
        fw[i] = H_ACT;
        if ($urandom_range(0, 19) == 0) fw[i] = $urandom_range(0, 1) ? H_ACT + 1 : H_ACT - 1;
      end
      drive_frame(n, 1'($urandom));
    end

    repeat (4) @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
